// File: rtl/indirect_mem_sequencer_if.sv
// Data-memory port bundle between the indirect sequencer (master)
// and the data cache (slave).
interface indirect_mem_sequencer_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
);
   logic                  dmem_read;
   logic                  dmem_write;
   logic [ADDR_WIDTH-1:0] dmem_addr;
   logic [DATA_WIDTH-1:0] dmem_wdata;
   logic                  dmem_resp;
   logic [DATA_WIDTH-1:0] dmem_rdata;

   modport master (
      output dmem_read,
      output dmem_write,
      output dmem_addr,
      output dmem_wdata,
      input  dmem_resp,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_read,
      input  dmem_write,
      input  dmem_addr,
      input  dmem_wdata,
      output dmem_resp,
      output dmem_rdata
   );
endinterface

// File: rtl/indirect_mem_sequencer.sv
// MEM-stage data-port sequencer. Plain loads/stores pass straight through;
// LDI/STI become a pointer read followed by a data read or write at the
// fetched pointer. Request outputs are combinational; state is registered.
module indirect_mem_sequencer #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_is_ldi,
   input  logic                  mem_is_sti,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_wdata,
   indirect_mem_sequencer_if.master dmem,
   output logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  sti_ldi_sig,
   output logic                  mem_memread,
   output logic                  mem_memwrite,
   output logic                  mem_mem_resp
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PTR  = 2'd1,
      DATA = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic [DATA_WIDTH-1:0] ptr_q;
   logic [DATA_WIDTH-1:0] ptr_d;
   logic                  is_ldi_q;
   logic                  is_ldi_d;

   logic                  req_read;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  req_sti_ldi;

   // Next-state, pointer capture and data-port request decode; all requests forced low in reset.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      is_ldi_d    = is_ldi_q;
      req_read    = 1'b0;
      req_write   = 1'b0;
      req_addr    = {ADDR_WIDTH{1'b0}};
      req_wdata   = {DATA_WIDTH{1'b0}};
      req_sti_ldi = 1'b0;
      if (!rst_n) begin
         state_d  = IDLE;
         ptr_d    = {DATA_WIDTH{1'b0}};
         is_ldi_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (mem_is_ldi || mem_is_sti) begin
                  // LDI wins when both decode bits are set
                  req_read    = 1'b1;
                  req_addr    = mem_addr;
                  req_sti_ldi = 1'b1;
                  is_ldi_d    = mem_is_ldi;
                  if (dmem.dmem_resp) begin
                     ptr_d   = dmem.dmem_rdata;
                     state_d = DATA;
                  end else begin
                     state_d = PTR;
                  end
               end else begin
                  req_read  = mem_read;
                  req_write = mem_write;
                  req_addr  = mem_addr;
                  req_wdata = mem_wdata;
               end
            end
            PTR: begin
               req_read    = 1'b1;
               req_addr    = mem_addr;
               req_sti_ldi = 1'b1;
               if (dmem.dmem_resp) begin
                  ptr_d   = dmem.dmem_rdata;
                  state_d = DATA;
               end else begin
                  state_d = PTR;
               end
            end
            DATA: begin
               // stall on a miss here comes from the hazard unit's cache-miss path
               req_addr = ptr_q;
               if (is_ldi_q) begin
                  req_read = 1'b1;
               end else begin
                  req_write = 1'b1;
                  req_wdata = mem_wdata;
               end
               if (dmem.dmem_resp) begin
                  state_d = IDLE;
               end else begin
                  state_d = DATA;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State, pointer and access-type registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= {DATA_WIDTH{1'b0}};
         is_ldi_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         is_ldi_q <= is_ldi_d;
      end
   end

   assign dmem.dmem_read  = req_read;
   assign dmem.dmem_write = req_write;
   assign dmem.dmem_addr  = req_addr;
   assign dmem.dmem_wdata = req_wdata;
   assign mem_rdata       = dmem.dmem_rdata;
   assign sti_ldi_sig     = req_sti_ldi;
   assign mem_memread     = req_read;
   assign mem_memwrite    = req_write;
   assign mem_mem_resp    = dmem.dmem_resp;

endmodule

// File: tb/tb_indirect_mem_sequencer.sv
// Self-checking bench for indirect_mem_sequencer: directed scenarios plus
// randomized plain/indirect traffic against a per-phase reference model.
module tb_indirect_mem_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_is_ldi, mem_is_sti, mem_read, mem_write;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata;
   logic        sti_ldi_sig, mem_memread, mem_memwrite, mem_mem_resp;

   int vectors    = 0;
   int miscompares = 0;

   indirect_mem_sequencer_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

   indirect_mem_sequencer #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_is_ldi   (mem_is_ldi),
      .mem_is_sti   (mem_is_sti),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .dmem         (bus.master),
      .mem_rdata    (mem_rdata),
      .sti_ldi_sig  (sti_ldi_sig),
      .mem_memread  (mem_memread),
      .mem_memwrite (mem_memwrite),
      .mem_mem_resp (mem_mem_resp)
   );

   always #5 clk = ~clk;

   // One plain (non-indirect) cycle: every output must equal a direct connection.
   task automatic run_plain(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [15:0] wdata, input logic resp,
                            input logic [15:0] rdata, input string name);
      logic [53:0] got, exp;
      mem_is_ldi = 1'b0; mem_is_sti = 1'b0;
      mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wdata;
      bus.dmem_resp = resp; bus.dmem_rdata = rdata;
      #1;
      got = {bus.dmem_read, bus.dmem_write, sti_ldi_sig, mem_memread, mem_memwrite,
             mem_mem_resp, bus.dmem_addr, bus.dmem_wdata, mem_rdata};
      exp = {rd, wr, 1'b0, rd, wr, resp, addr, wdata, rdata};
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
      @(negedge clk);
   endtask

   // One indirect instruction: lp miss cycles on the pointer read, ld on the final access.
   task automatic run_indirect(input logic ldi, input logic sti, input logic [15:0] addr,
                               input logic [15:0] ptr, input logic [15:0] data,
                               input logic [15:0] wdata, input int lp, input int ld,
                               input string name);
      int          total;
      int          writes_done;
      logic        pphase, resp, e_ldi, e_read, e_write;
      logic [15:0] e_addr, rdv;
      logic [37:0] got, exp;
      total       = lp + ld + 2;
      writes_done = 0;
      e_ldi       = ldi;   // LDI wins on conflicting decode
      for (int c = 0; c < total; c++) begin
         pphase = (c <= lp);
         resp   = pphase ? (c == lp) : (c == total - 1);
         rdv    = pphase ? ptr : data;
         if (c == 0) begin
            mem_is_ldi = ldi; mem_is_sti = sti;
         end else begin
            {mem_is_ldi, mem_is_sti} = 2'($urandom);
         end
         {mem_read, mem_write} = 2'($urandom);
         mem_addr  = pphase ? addr : 16'($urandom);
         mem_wdata = pphase ? 16'($urandom) : wdata;
         bus.dmem_resp  = resp;
         bus.dmem_rdata = rdv;
         #1;
         e_read  = pphase ? 1'b1 : e_ldi;
         e_write = pphase ? 1'b0 : ~e_ldi;
         e_addr  = pphase ? addr : ptr;
         got = {bus.dmem_read, bus.dmem_write, sti_ldi_sig, mem_memread, mem_memwrite,
                mem_mem_resp, bus.dmem_addr, mem_rdata};
         exp = {e_read, e_write, pphase, e_read, e_write, resp, e_addr, rdv};
         vectors++;
         if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, got, exp);
         end
         if (e_write) begin
            vectors++;
            if (bus.dmem_wdata !== wdata) begin
               miscompares++;
               $display("FAIL %s wdata cycle %0d: got %h expected %h", name, c, bus.dmem_wdata, wdata);
            end
         end
         if (bus.dmem_write === 1'b1 && resp) writes_done++;
         @(negedge clk);
      end
      if (!e_ldi) begin
         vectors++;
         if (writes_done != 1) begin
            miscompares++;
            $display("FAIL %s write count: got %0d expected 1", name, writes_done);
         end
      end
   endtask

   task automatic test_reset();
      logic [4:0] got;
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         mem_is_ldi = 1'b1; mem_is_sti = 1'b0; mem_read = 1'b1; mem_write = 1'b1;
         mem_addr = 16'h3000; mem_wdata = 16'($urandom);
         bus.dmem_resp = 1'b1; bus.dmem_rdata = 16'h4010;
         #1;
         got = {bus.dmem_read, bus.dmem_write, sti_ldi_sig,
                |bus.dmem_addr, |bus.dmem_wdata};
         vectors++;
         if (got !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset_outputs cycle %0d: got %b expected 00000", c, got);
         end
         @(negedge clk);
      end
      rst_n = 1'b1;
      run_indirect(1'b1, 1'b0, 16'h3000, 16'h4010, 16'hBEEF, 16'h0000, 0, 0, "reset_release_ldi");
      run_plain(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "reset_release_idle");
   endtask

   task automatic test_ldi_hits();
      run_indirect(1'b1, 1'b0, 16'h3000, 16'h4010, 16'hBEEF, 16'h0000, 0, 0, "ldi_hits");
      run_plain(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "ldi_hits_idle");
   endtask

   task automatic test_sti_misses();
      run_indirect(1'b0, 1'b1, 16'h1000, 16'h2222, 16'h0000, 16'h5A5A, 3, 3, "sti_misses");
      run_plain(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "sti_misses_idle");
   endtask

   task automatic test_plain();
      run_plain(1'b0, 1'b1, 16'h0042, 16'h1234, 1'b1, 16'h0000, "plain_store_hit");
      run_plain(1'b0, 1'b1, 16'h0042, 16'h1234, 1'b0, 16'h0000, "plain_store_miss");
      run_plain(1'b1, 1'b0, 16'h0042, 16'h1234, 1'b1, 16'hCAFE, "plain_load");
      run_plain(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h9999, "idle_resp_ignored");
      run_plain(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "plain_stays_idle");
   endtask

   task automatic test_reset_mid();
      mem_is_ldi = 1'b0; mem_is_sti = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
      mem_addr = 16'h1000; mem_wdata = 16'h5A5A;
      bus.dmem_resp = 1'b1; bus.dmem_rdata = 16'h2222;
      @(negedge clk);
      bus.dmem_resp = 1'b0;
      #1;
      vectors++;
      if ({bus.dmem_write, bus.dmem_addr} !== {1'b1, 16'h2222}) begin
         miscompares++;
         $display("FAIL reset_mid_data: got %h expected 12222", {bus.dmem_write, bus.dmem_addr});
      end
      rst_n = 1'b0;
      #1;
      vectors++;
      if ({bus.dmem_read, bus.dmem_write, sti_ldi_sig} !== 3'b000) begin
         miscompares++;
         $display("FAIL reset_mid_forced: got %b expected 000",
                  {bus.dmem_read, bus.dmem_write, sti_ldi_sig});
      end
      @(negedge clk);
      vectors++;
      if (dut.ptr_q !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_mid_ptr: got %h expected 0000", dut.ptr_q);
      end
      rst_n = 1'b1;
      run_plain(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "reset_mid_no_write");
   endtask

   task automatic test_conflict();
      run_indirect(1'b1, 1'b1, 16'h0123, 16'h0456, 16'h0789, 16'h0000, 1, 1, "conflict_is_ldi");
   endtask

   task automatic test_back_to_back();
      run_indirect(1'b0, 1'b1, 16'h0A00, 16'h0B00, 16'h0000, 16'h1111, 0, 0, "b2b_first");
      run_indirect(1'b1, 1'b0, 16'h0C00, 16'h0D00, 16'h2222, 16'h0000, 0, 2, "b2b_second");
      run_indirect(1'b0, 1'b1, 16'h0E00, 16'h0F00, 16'h0000, 16'h3333, 2, 0, "b2b_third");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            run_plain(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                      1'($urandom), 16'($urandom), "rand_plain");
         end else begin
            logic ldi, sti;
            ldi = 1'($urandom);
            sti = ldi ? 1'($urandom) : 1'b1;
            run_indirect(ldi, sti, 16'($urandom), 16'($urandom), 16'($urandom),
                         16'($urandom), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), "rand_indirect");
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      mem_is_ldi = 1'b0; mem_is_sti = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_addr = 16'h0000; mem_wdata = 16'h0000;
      bus.dmem_resp = 1'b0; bus.dmem_rdata = 16'h0000;
      @(negedge clk);
      test_reset();
      test_ldi_hits();
      test_sti_misses();
      test_plain();
      test_reset_mid();
      test_conflict();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
